watch_scan_mux: RTL
===================

// Module: watch_scan_mux
// PURPOSE
//  Parametrised debug-watch selector between the CPU watch signals and LedDisplay.
//  Picks one of NUM_CH packed watch channels for the display, in one of three modes:
//  - manual select
//  - timed auto-scan
//  - freeze: snapshots every channel at once, so a running CPU can be inspected
//    coherently.
//  Output is registered and is driven straight into LedDisplay's data input.
// PARAMETERS
//  NUM_CH    16        number of watch channels (2..64)
//  CH_W      32        width of each channel; narrower watches are zero-extended by the instantiator
//  SEL_W     $clog2(NUM_CH)  channel-index width (derived, do not override)
//  SCAN_DIV  50_000_000 clk cycles per channel step in SCAN mode (>=2)
// PORTS
//  clk         in   1            system clock
//  rst         in   1            async reset, active-low
//  watch_bus   in   NUM_CH*CH_W  channel k = watch_bus[k*CH_W +: CH_W]
//  mode        in   2            00 MANUAL, 01 SCAN, 10 FREEZE, 11 = MANUAL
//  sel_in      in   SEL_W        channel index used in MANUAL mode
//  step        in   1            async push-button; each rising edge advances channel (SCAN/FREEZE)
//  out         out  CH_W         selected channel value, registered
//  cur_sel     out  SEL_W        channel index currently shown
//  frozen      out  1            1 while out is sourced from the snapshot
// BEHAVIOUR
//  Reset (rst=0, async): out=0, cur_sel=0, frozen=0, prescaler=0, snapshot=0, step sync regs=0.
//  step: 2-flop synchroniser, then rising-edge detect -> step_p (1-clk pulse); 3 clk from pin to pulse.
//  FSM states: S_MAN, S_SCAN, S_FRZ. State follows mode every clk (mode is the only transition source).
//  - S_MAN:  cur_sel <= sel_in; prescaler held at 0; frozen=0.
//  - S_SCAN: prescaler counts 0..SCAN_DIV-1. On terminal count OR step_p, cur_sel advances by 1 and
//            prescaler <= 0. Both events in the same clk advance by exactly 1.
//            Wrap: cur_sel==NUM_CH-1 -> 0. On entry, cur_sel is kept (no jump) and prescaler <= 0.
//  - S_FRZ:  on the entry clk (prev state != S_FRZ) the snapshot registers <= watch_bus, all channels
//            in the same edge, and frozen <= 1. While in S_FRZ the snapshot is not reloaded.
//            step_p advances cur_sel with the same wrap rule; prescaler held.
//            Leaving S_FRZ: frozen <= 0, snapshot kept but unused.
//            Re-entering S_FRZ takes a fresh snapshot.
//  Data path: out <= (frozen_next ? snapshot : watch_bus)[cur_sel_next]. 1-clk latency from
//    sel/mode/watch change to out. Index >= NUM_CH (non-power-of-2 NUM_CH, MANUAL only) -> out <= 0,
//    and cur_sel shows the raw index.
//  Entry clk into S_FRZ: out already shows the snapshot value of the captured edge.
//    The snapshot write and the out mux both use watch_bus in that clk.
//  Reset mid-scan or mid-freeze returns to the reset values immediately. The state after reset
//    follows mode on the first clk edge; a freeze entered this way captures on that edge.
//  Arithmetic: prescaler width $clog2(SCAN_DIV); cur_sel increment is modulo NUM_CH (explicit compare,
//    not natural overflow).
// STRUCTURE
//  Shared package/include (watch_defs.v): MODE_MANUAL/MODE_SCAN/MODE_FREEZE codes, S_* state codes.
//  Sub-module: btn_edge_sync (2-flop sync + rising-edge pulse). It is reused for other board buttons.
//  Snapshot = NUM_CH*CH_W flop array. The mux is an indexed part-select, not a case list.
// TESTING (NUM_CH=16, CH_W=32, SCAN_DIV=4 unless noted; channel k driven with 32'hA000_0000+k)
//  1. MANUAL, sel_in=5 -> out=32'hA000_0005 one clk later; cur_sel=5, frozen=0.
//  2. SCAN from cur_sel=14 -> cur_sel 15,0,1 on every 4th clk; out follows, one clk behind.
//     Wrap 15->0 is checked.
//  3. SCAN, step edge lands on the terminal-count clk -> cur_sel advances by exactly 1.
//  4. FREEZE entered, then every channel changed to 32'h5555_0000+k.
//     -> out still shows A000_000k while step walks channels 0..15; frozen=1.
//     Return to MANUAL -> live 5555_000k values appear.
//  5. NUM_CH=10, MANUAL sel_in=12 -> out=0, cur_sel=12.
//  6. rst low mid-SCAN and mid-FREEZE (asynchronous, between edges) -> out, cur_sel, frozen go to 0
//     without waiting for clk. Release in FREEZE -> fresh snapshot on the first edge.

Source files
------------

// File: rtl/watch_scan_mux_pkg.sv
// Shared mode and state codes for the debug-watch selector.
package watch_scan_mux_pkg;

   localparam logic [1:0] MODE_MANUAL = 2'b00;
   localparam logic [1:0] MODE_SCAN   = 2'b01;
   localparam logic [1:0] MODE_FREEZE = 2'b10;

   typedef enum logic [1:0] {
      S_MAN  = 2'b00,
      S_SCAN = 2'b01,
      S_FRZ  = 2'b10
   } state_t;

   // Mode code 11 is an alias for manual.
   function automatic state_t mode_to_state(input logic [1:0] m);
      case (m)
         MODE_SCAN:   return S_SCAN;
         MODE_FREEZE: return S_FRZ;
         default:     return S_MAN;
      endcase
   endfunction

endpackage

// File: rtl/watch_scan_mux_btn_edge_sync.sv
// Push-button synchroniser: 2-flop sync, then a registered one-clock rising-edge pulse.
module btn_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);

   logic s1, s2, prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         prev  <= 1'b0;
         pulse <= 1'b0;
      end else begin
         s1    <= btn;
         s2    <= s1;
         prev  <= s2;
         pulse <= s2 & ~prev;
      end
   end

endmodule

// File: rtl/watch_scan_mux.sv
// Debug-watch selector feeding LedDisplay: manual pick, timed auto-scan, or frozen snapshot.
module watch_scan_mux
   import watch_scan_mux_pkg::*;
#(
   parameter int NUM_CH   = 16,
   parameter int CH_W     = 32,
   parameter int SCAN_DIV = 50_000_000,
   localparam int SEL_W   = $clog2(NUM_CH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_CH*CH_W-1:0] watch_bus,
   input  logic [1:0]             mode,
   input  logic [SEL_W-1:0]       sel_in,
   input  logic                   step,
   output logic [CH_W-1:0]        out,
   output logic [SEL_W-1:0]       cur_sel,
   output logic                   frozen
);

   localparam int PS_W = $clog2(SCAN_DIV);

   state_t                 state, state_nx;
   logic [PS_W-1:0]        presc, presc_nx;
   logic [SEL_W-1:0]       cur_sel_nx, sel_inc;
   logic                   frozen_nx, snap_ld, step_p, tc;
   logic [NUM_CH*CH_W-1:0] snapshot, src;
   logic [CH_W-1:0]        out_nx;

   btn_edge_sync u_step (
      .clk   (clk),
      .rst   (rst),
      .btn   (step),
      .pulse (step_p)
   );

   assign tc      = (presc == PS_W'(SCAN_DIV - 1));
   // Compare with >= so a raw out-of-range manual index still wraps cleanly.
   assign sel_inc = (int'(cur_sel) >= NUM_CH - 1) ? '0 : cur_sel + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_MAN;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx   = mode_to_state(mode);
      cur_sel_nx = cur_sel;
      presc_nx   = presc;
      frozen_nx  = 1'b0;
      snap_ld    = 1'b0;
      case (state_nx)
         S_MAN: begin
            cur_sel_nx = sel_in;
            presc_nx   = '0;
         end
         S_SCAN: begin
            if (state != S_SCAN) begin
               presc_nx = '0;
            end else if (tc || step_p) begin
               presc_nx   = '0;
               cur_sel_nx = sel_inc;
            end else begin
               presc_nx = presc + PS_W'(1);
            end
         end
         S_FRZ: begin
            frozen_nx = 1'b1;
            snap_ld   = (state != S_FRZ);
            if (step_p) cur_sel_nx = sel_inc;
         end
         default: ;
      endcase
   end

   // On the capture edge the snapshot equals watch_bus, so the live bus is muxed directly.
   assign src    = (frozen_nx && !snap_ld) ? snapshot : watch_bus;
   assign out_nx = (int'(cur_sel_nx) < NUM_CH) ? src[int'(cur_sel_nx)*CH_W +: CH_W] : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out      <= '0;
         cur_sel  <= '0;
         frozen   <= 1'b0;
         presc    <= '0;
         snapshot <= '0;
      end else begin
         out     <= out_nx;
         cur_sel <= cur_sel_nx;
         frozen  <= frozen_nx;
         presc   <= presc_nx;
         if (snap_ld) snapshot <= watch_bus;
      end
   end

endmodule
